// File: rtl/nes_pad_if.sv
// Pad-side and decoded-button signals of the NES/SNES pad reader.
// master = the reader, slave = the pad plus whatever consumes the buttons.
interface nes_pad_if;
  logic        NData;
  logic        NLatch;
  logic        NClk;
  logic        NU;
  logic        ND;
  logic        NL;
  logic        NR;
  logic        NReadable;
  logic [15:0] Buttons;

  modport master (
    input  NData,
    output NLatch, NClk, NU, ND, NL, NR, NReadable, Buttons
  );

  modport slave (
    output NData,
    input  NLatch, NClk, NU, ND, NL, NR, NReadable, Buttons
  );
endinterface

// File: rtl/nes_pad_reader.sv
// Periodically latches and shifts in an NES (8-bit) or SNES (16-bit) pad and
// publishes the active-high button set once per completed frame.
module nes_pad_reader #(
  parameter int HALF = 300,
  parameter int POLL = 833333,
  parameter int SNES = 0
) (
  input  logic       CLK,
  input  logic       RST,
  nes_pad_if.master  pad
);

  localparam int NBITS = (SNES != 0) ? 16 : 8;
  localparam int IW    = $clog2(NBITS);
  localparam int PW    = $clog2(POLL);
  localparam int CW    = $clog2(2 * HALF);

  typedef enum logic [2:0] {IDLE, LATCH, CLK_LO, CLK_HI, DONE} state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [PW-1:0]     poll_reg;
  logic [CW-1:0]     phase_reg;
  logic [4:0]        bit_reg;
  logic [1:0]        sync_reg;
  logic [NBITS-1:0]  frame_reg;
  logic              presence_reg;
  logic [15:0]       buttons_reg;
  logic              readable_reg;
  logic [15:0]       buttons_next;

  logic nlatch;
  logic nclk;
  logic phase_end;
  logic sample;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (poll_reg == '0) state_next = LATCH;
      LATCH:   if (phase_end) state_next = CLK_LO;
      CLK_LO:  if (phase_end) state_next = CLK_HI;
      CLK_HI:  if (phase_end) state_next = (bit_reg == 5'(NBITS)) ? DONE : CLK_LO;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; sampling happens on the last cycle of LATCH and of each CLK_HI
  always_comb begin
    nlatch    = 1'b0;
    nclk      = 1'b1;
    phase_end = 1'b0;
    sample    = 1'b0;
    case (state_reg)
      LATCH: begin
        nlatch    = 1'b1;
        phase_end = (phase_reg == CW'(2 * HALF - 1));
        sample    = phase_end;
      end
      CLK_LO: begin
        nclk      = 1'b0;
        phase_end = (phase_reg == CW'(HALF - 1));
      end
      CLK_HI: begin
        phase_end = (phase_reg == CW'(HALF - 1));
        sample    = phase_end;
      end
      default: ;
    endcase
  end

  // Pad reads active-low; an open line (presence bit 1) reports nothing pressed
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_btn
      if (gi < NBITS) begin : g_used
        assign buttons_next[gi] = ~frame_reg[gi] & ~presence_reg;
      end else begin : g_unused
        assign buttons_next[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      poll_reg     <= '0;
      phase_reg    <= '0;
      bit_reg      <= '0;
      sync_reg     <= 2'b11;
      frame_reg    <= '0;
      presence_reg <= 1'b0;
      buttons_reg  <= '0;
      readable_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], pad.NData};
      poll_reg <= (poll_reg == PW'(POLL - 1)) ? '0 : poll_reg + 1'b1;

      if (state_reg == IDLE || state_next != state_reg) begin
        phase_reg <= '0;
      end else begin
        phase_reg <= phase_reg + 1'b1;
      end

      // bit_reg names the raw bit sampled at the end of the current half-period pair
      if (state_reg == IDLE) begin
        bit_reg <= '0;
      end else if (state_next == CLK_LO && state_reg != CLK_LO) begin
        bit_reg <= bit_reg + 1'b1;
      end

      if (sample) begin
        if (bit_reg < 5'(NBITS)) begin
          frame_reg[bit_reg[IW-1:0]] <= sync_reg[1];
        end else begin
          presence_reg <= sync_reg[1];
        end
      end

      if (state_reg == DONE) begin
        buttons_reg  <= buttons_next;
        readable_reg <= ~presence_reg;
      end
    end
  end

  assign pad.NLatch    = nlatch;
  assign pad.NClk      = nclk;
  assign pad.Buttons   = buttons_reg;
  assign pad.NU        = buttons_reg[4];
  assign pad.ND        = buttons_reg[5];
  assign pad.NL        = buttons_reg[6];
  assign pad.NR        = buttons_reg[7];
  assign pad.NReadable = readable_reg;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Scoreboard bench: an NES and an SNES reader each talk to a behavioural pad;
// a monitor checks frame timing and compares outputs against queued expectations.
module tb_nes_pad_reader;

  localparam int HALF = 4;
  localparam int POLL = 200;

  typedef struct packed {
    logic [15:0] btn;
    logic        rdy;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  nes_pad_if a_if ();
  nes_pad_if b_if ();

  nes_pad_reader #(.HALF(HALF), .POLL(POLL), .SNES(0)) dut_a (
    .CLK (CLK),
    .RST (RST),
    .pad (a_if)
  );

  nes_pad_reader #(.HALF(HALF), .POLL(POLL), .SNES(1)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .pad (b_if)
  );

  always #5 CLK = ~CLK;

  // Behavioural pads: latch loads bit 0, each NClk rise presents the next bit,
  // bits past the button field read 0 on a real pad.
  logic [15:0] btn_a = 16'h0000;
  logic [15:0] btn_b = 16'h0000;
  logic        plug_a = 1'b1;
  logic        plug_b = 1'b1;
  int          ptr_a = 0;
  int          ptr_b = 0;

  always @(posedge a_if.NClk or posedge a_if.NLatch) begin
    if (a_if.NLatch) ptr_a <= 0;
    else             ptr_a <= ptr_a + 1;
  end

  always @(posedge b_if.NClk or posedge b_if.NLatch) begin
    if (b_if.NLatch) ptr_b <= 0;
    else             ptr_b <= ptr_b + 1;
  end

  assign a_if.NData = !plug_a ? 1'b1 : (ptr_a < 8)  ? ~btn_a[ptr_a[3:0]] : 1'b0;
  assign b_if.NData = !plug_b ? 1'b1 : (ptr_b < 16) ? ~btn_b[ptr_b[3:0]] : 1'b0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;
  int fcyc[2]      = '{-1, -1};
  int last_rise[2] = '{-1, -1};
  int frames[2]    = '{0, 0};
  int lat_hi[2];
  int lo_run[2];
  int pulses[2];
  bit lo_bad[2];
  logic prev_lat[2] = '{1'b0, 1'b0};
  logic prev_clk[2] = '{1'b1, 1'b1};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_frames(input int i, input int n);
    int k;
    k = 0;
    while (frames[i] < n && k < 1000) begin
      @(negedge CLK);
      k++;
    end
    if (frames[i] < n) check("frame_timeout", frames[i], n);
  endtask

  // Monitor: tracks each frame from the latch rise, pops and compares when outputs update
  initial begin : monitor
    exp_t        e;
    logic        l, c, r;
    logic [15:0] b;
    logic [3:0]  d;
    int          nb, fend;
    bit          have;
    string       tag;
    forever begin
      @(negedge CLK);
      cycle++;
      for (int i = 0; i < 2; i++) begin
        if (i == 0) begin
          l = a_if.NLatch; c = a_if.NClk; b = a_if.Buttons; r = a_if.NReadable;
          d = {a_if.NR, a_if.NL, a_if.ND, a_if.NU}; nb = 8; tag = "nes";
        end else begin
          l = b_if.NLatch; c = b_if.NClk; b = b_if.Buttons; r = b_if.NReadable;
          d = {b_if.NR, b_if.NL, b_if.ND, b_if.NU}; nb = 16; tag = "snes";
        end
        fend = 2 * HALF * (nb + 1) + 1;
        if (RST) begin
          fcyc[i] = -1;
          last_rise[i] = -1;
          prev_lat[i] = 1'b0;
          prev_clk[i] = 1'b1;
        end else begin
          if (l && !prev_lat[i]) begin
            if (last_rise[i] >= 0) check({tag, "_poll_interval"}, cycle - last_rise[i], POLL);
            last_rise[i] = cycle;
            fcyc[i] = 0; lat_hi[i] = 0; lo_run[i] = 0; pulses[i] = 0; lo_bad[i] = 1'b0;
          end
          if (fcyc[i] >= 0) begin
            if (l) lat_hi[i]++;
            if (!c) begin
              lo_run[i]++;
            end else if (!prev_clk[i]) begin
              pulses[i]++;
              if (lo_run[i] != HALF) lo_bad[i] = 1'b1;
              lo_run[i] = 0;
            end
            if (fcyc[i] == fend) begin
              have = (i == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
              if (have) begin
                if (i == 0) e = exp_q0.pop_front();
                else        e = exp_q1.pop_front();
                check({tag, "_latch_width"}, lat_hi[i], 2 * HALF);
                check({tag, "_nclk_pulses"}, pulses[i], nb);
                check({tag, "_nclk_low_width_bad"}, int'(lo_bad[i]), 0);
                check({tag, "_buttons"}, int'(b), int'(e.btn));
                check({tag, "_readable"}, int'(r), int'(e.rdy));
                check({tag, "_dirs_RLDU"}, int'(d), int'(e.btn[7:4]));
              end
              $display("frame %s #%0d: Buttons=%04h NReadable=%0b dirs(RLDU)=%04b", tag, frames[i] + 1, b, r, d);
              frames[i]++;
              fcyc[i] = -1;
            end else begin
              fcyc[i]++;
            end
          end
          prev_lat[i] = l;
          prev_clk[i] = c;
        end
      end
    end
  end

  initial begin : stimulus
    int k;
    // Held in reset: outputs at their idle values
    RST = 1'b1;
    btn_a = 16'h0090;  // Up + Right
    btn_b = 16'h0500;  // A + L
    repeat (3) @(posedge CLK);
    #1;
    check("rst_nlatch", int'(a_if.NLatch), 0);
    check("rst_nclk", int'(a_if.NClk), 1);
    check("rst_dirs", int'({a_if.NR, a_if.NL, a_if.ND, a_if.NU}), 0);
    check("rst_readable", int'(a_if.NReadable), 0);
    check("rst_buttons", int'(a_if.Buttons), 0);
    check("rst_snes_buttons", int'(b_if.Buttons), 0);
    check("rst_snes_nclk", int'(b_if.NClk), 1);

    exp_q0.push_back({16'h0090, 1'b1});
    exp_q1.push_back({16'h0500, 1'b1});
    @(posedge CLK);
    #2 RST = 1'b0;
    wait_frames(0, 1);

    // No pad: open line reads all ones
    plug_a = 1'b0;
    exp_q0.push_back({16'h0000, 1'b0});
    wait_frames(0, 2);

    // A + B + Select + Start
    plug_a = 1'b1;
    btn_a = 16'h000F;
    exp_q0.push_back({16'h000F, 1'b1});
    wait_frames(0, 3);

    // All four directions, no arbitration
    btn_a = 16'h00F0;
    exp_q0.push_back({16'h00F0, 1'b1});
    wait_frames(0, 4);

    // Up only, then abort the following frame in CLK_HI of bit 5
    btn_a = 16'h0010;
    exp_q0.push_back({16'h0010, 1'b1});
    wait_frames(0, 5);
    wait_frames(1, 1);

    k = 0;
    @(negedge CLK);
    while (!a_if.NLatch && k < 400) begin
      @(negedge CLK);
      k++;
    end
    if (!a_if.NLatch) check("latch_timeout", 0, 1);
    repeat (2 * HALF + 8 * 4 + HALF + 1) @(posedge CLK);
    #3;
    check("nclk_before_rst", int'(a_if.NClk), 1);
    check("nu_before_rst", int'(a_if.NU), 1);
    RST = 1'b1;
    #1;
    check("abort_nclk", int'(a_if.NClk), 1);
    check("abort_nlatch", int'(a_if.NLatch), 0);
    check("abort_nu", int'(a_if.NU), 0);
    check("abort_buttons", int'(a_if.Buttons), 0);
    check("abort_readable", int'(a_if.NReadable), 0);

    // Fresh frame after release: Up + Left
    btn_a = 16'h0050;
    exp_q0.push_back({16'h0050, 1'b1});
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    wait_frames(0, 6);
    check("scoreboard_drained", exp_q0.size() + exp_q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nes_pad_reader.md
NES_PAD_READER -- requirements
Module: nes_pad_reader

Interface
REQ-001 Parameter HALF, default 300: CLK cycles per NClk half-period (6 us at 50 MHz); SHALL be >= 3.
REQ-002 Parameter POLL, default 833333: CLK cycles between consecutive latch rising edges (60 Hz at 50 MHz); SHALL exceed 2*HALF*(NBITS+1)+1.
REQ-003 Parameter SNES, default 0: 0 = NES pad, NBITS=8; 1 = SNES pad, NBITS=16.
REQ-004 CLK  input  1  system clock; all logic on rising edge.
REQ-005 RST  input  1  asynchronous reset, active-high.
REQ-006 NData  input  1  pad serial data; active-low button state; asynchronous to CLK.
REQ-007 NLatch  output  1  pad latch strobe; active-high.
REQ-008 NClk  output  1  pad shift clock; idles high.
REQ-009 NU, ND, NL, NR  output  1 each  Up/Down/Left/Right pressed; active-high.
REQ-010 NReadable  output  1  last completed frame came from a connected pad.
REQ-011 Buttons  output  16  all buttons from last frame, active-high.

Function
REQ-012 NData SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-013 FSM states SHALL be IDLE, LATCH, CLK_LO, CLK_HI, DONE.
REQ-014 A free-running poll counter SHALL start a frame (IDLE->LATCH) every POLL cycles; the first frame starts on the first cycle after RST deasserts.
REQ-015 LATCH: NLatch=1, NClk=1 for exactly 2*HALF cycles; raw bit 0 sampled on its last cycle.
REQ-016 For k=1..NBITS: CLK_LO (NClk=0, HALF cycles), then CLK_HI (NClk=1, HALF cycles); raw bit k sampled on the last CLK_HI cycle.
REQ-017 After raw bit NBITS is sampled: DONE for one cycle, then IDLE; NLatch=0 and NClk=1 in IDLE and DONE.
REQ-018 Raw bits 0..NBITS-1 SHALL shift into a frame register; raw bit NBITS is the presence bit (real pads shift in 0; an open line reads 1).
REQ-019 In DONE, if presence bit = 0: Buttons[NBITS-1:0] = inverted raw bits, unused upper Buttons bits = 0, NReadable = 1.
REQ-020 In DONE, if presence bit = 1: Buttons = 0, NReadable = 0.
REQ-021 Bit map NES: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right; Buttons[15:8] = 0.
REQ-022 Bit map SNES: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 12-15 as read.
REQ-023 NU/ND/NL/NR SHALL equal registered Buttons[4]/[5]/[6]/[7] and NReadable SHALL be registered; all update only in DONE and hold between frames.
REQ-024 Opposing directions (Up+Down, Left+Right) SHALL be reported as read, without arbitration.
REQ-025 Frame timing SHALL be independent of NData content; a pad unplugged mid-frame changes only that frame's result.

Reset
REQ-026 While RST=1: state IDLE, NLatch=0, NClk=1, NU=ND=NL=NR=0, NReadable=0, Buttons=0, frame register and counters cleared, synchronizer flops = 1.
REQ-027 RST asserted mid-frame SHALL abort the frame immediately (asynchronously) with no output update; a fresh frame starts the cycle after release.

Verification (HALF=4, POLL=200)
REQ-028 Reset: RST=1 at any point -> NLatch=0, NClk=1, all direction outputs 0, NReadable=0, Buttons=16'h0000.
REQ-029 Timing: NLatch high exactly 8 cycles; 8 NClk low pulses of 4 cycles each; latch rising edges exactly 200 cycles apart; DONE 73 cycles after latch rise.
REQ-030 NES model, Up+Right pressed (raw b4=0, b7=0, b8=0, others 1) -> NU=1, NR=1, ND=0, NL=0, NReadable=1, Buttons=16'h0090.
REQ-031 NData held 1 (no pad) -> NReadable=0, NU=ND=NL=NR=0, Buttons=16'h0000.
REQ-032 SNES=1 model, A+L pressed, raw b16=0 -> Buttons=16'h0500, NReadable=1, directions 0, 16 NClk pulses.
REQ-033 RST pulsed during CLK_HI of bit 5 after a prior Up frame -> NClk=1 and NU=0 at once; after release, next frame completes normally with correct values.
